// File: rtl/fb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fb_arbiter_pkg
// Shared constants, swap-state encoding and the display index helper for the
// double-buffered framebuffer arbiter.
// ---------------------------------------------------------------------------
package fb_arbiter_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int FB_W_DEF   = 320;
    localparam int FB_H_DEF   = 240;

    localparam int FB_IDX_W   = 17;
    localparam int FB_ADDR_W  = 18;

    // First line of vertical blanking; the flip happens at its first pixel.
    localparam logic [9:0] VBLANK_LINE = 10'd480;

    typedef enum logic [0:0] {
        SWAP_IDLE = 1'b0,
        SWAP_PEND = 1'b1
    } swap_state_e;

    // Legacy-style constants for the swap state register.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    // Display coordinates are 2x the framebuffer, so both axes are halved.
    // Arithmetic is modulo 2^17; the RAM wraps any overflow.
    function automatic logic [FB_IDX_W-1:0] disp_index(
        input logic [9:0]  px,
        input logic [9:0]  py,
        input int unsigned fb_w
    );
        logic [FB_IDX_W-1:0] row_s;
        row_s = FB_IDX_W'(py[9:1]) * FB_IDX_W'(fb_w);
        return row_s + FB_IDX_W'(px[9:1]);
    endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// ---------------------------------------------------------------------------
// fb_arbiter_if
// Writer handshakes and RAM port of the framebuffer arbiter.
//   master : the arbiter (grants writers, drives the RAM strobes)
//   slave  : writers and RAM model (requests, read data)
// Signals: wr0/wr1 valid/addr/data/ready, ram_en/we/addr/wdata/rdata.
// ---------------------------------------------------------------------------
interface fb_arbiter_if
    import fb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic                 wr0_valid;
    logic [FB_IDX_W-1:0]  wr0_addr;
    logic [DATA_W-1:0]    wr0_data;
    logic                 wr0_ready;

    logic                 wr1_valid;
    logic [FB_IDX_W-1:0]  wr1_addr;
    logic [DATA_W-1:0]    wr1_data;
    logic                 wr1_ready;

    logic                 ram_en;
    logic                 ram_we;
    logic [FB_ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0]    ram_wdata;
    logic [DATA_W-1:0]    ram_rdata;

    modport master (
        input  wr0_valid, wr0_addr, wr0_data,
        input  wr1_valid, wr1_addr, wr1_data,
        output wr0_ready, wr1_ready,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport slave (
        output wr0_valid, wr0_addr, wr0_data,
        output wr1_valid, wr1_addr, wr1_data,
        input  wr0_ready, wr1_ready,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/fb_rr2.sv
// ---------------------------------------------------------------------------
// fb_rr2
// Two-requester round-robin grant. Grant is combinational; the last-grant
// pointer advances only when the granted request is accepted.
// Ports: clk, reset_n, req[1:0], accept, gnt[1:0].
// ---------------------------------------------------------------------------
module fb_rr2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    // last_r=1 means requester 1 won last, so requester 0 has priority next.
    logic last_r;

    // Combinational grant: lone requester wins, ties go to the one not last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_r ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Last-grant pointer; reset value makes requester 0 win first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_r <= 1'b1;
        end else if (accept) begin
            last_r <= gnt[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter
// Time-slotted arbiter sharing one synchronous RAM between the display read
// path (slot 0 of each 4-clk pixel period while video_on) and two writers
// (all other slots), with front/back bank flipping at the start of vblank.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   pixel_tick, video_on  timing strobe (slot 0) and visible-area flag
//   x, y                  display coordinates
//   swap_req / swap_ack   flip request / one-cycle pulse when flip happens
//   pix_data, front       registered pixel to DAC, current display bank
//   bus (master)          writer handshakes and RAM port
// Optional: define FB_ARB_STATS_EN to add starve0/starve1 saturating counters.
// ---------------------------------------------------------------------------
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FB_W   = FB_W_DEF,
    parameter int FB_H   = FB_H_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pixel_tick,
    input  logic              video_on,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic [DATA_W-1:0] pix_data,
    output logic              front,
`ifdef FB_ARB_STATS_EN
    output logic [15:0]       starve0,
    output logic [15:0]       starve1,
`endif
    fb_arbiter_if.master      bus
);

    if (FB_W * FB_H > (2 ** FB_IDX_W)) begin : g_geom_check
        $error("fb_arbiter: FB_W*FB_H exceeds the 17-bit index space");
    end

    logic                 display_slot_s;
    logic                 writer_slot_s;
    logic [1:0]           req_s;
    logic [1:0]           gnt_s;
    logic                 flip_s;
    logic                 ram_en_s;
    logic                 ram_we_s;
    logic [FB_ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0]    ram_wdata_s;

    logic [0:0]           state_r;
    logic                 front_r;
    logic                 cap_disp_r;
    logic                 cap_blank_r;
    logic [DATA_W-1:0]    pix_data_r;

    // Gating with reset_n keeps every strobe and grant low during reset.
    assign display_slot_s = reset_n & pixel_tick & video_on;
    assign writer_slot_s  = reset_n & ~display_slot_s;
    assign req_s          = {bus.wr1_valid, bus.wr0_valid} & {2{writer_slot_s}};

    fb_rr2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_s),
        .accept  (|gnt_s),
        .gnt     (gnt_s)
    );

    assign bus.wr0_ready = gnt_s[0];
    assign bus.wr1_ready = gnt_s[1];

    // RAM port mux: display read in slot 0, otherwise the granted writer.
    always_comb begin
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_addr_s  = {FB_ADDR_W{1'b0}};
        ram_wdata_s = {DATA_W{1'b0}};
        if (display_slot_s) begin
            ram_en_s   = 1'b1;
            ram_addr_s = {front_r, disp_index(x, y, FB_W)};
        end else if (gnt_s[0]) begin
            ram_en_s    = 1'b1;
            ram_we_s    = 1'b1;
            ram_addr_s  = {~front_r, bus.wr0_addr};
            ram_wdata_s = bus.wr0_data;
        end else if (gnt_s[1]) begin
            ram_en_s    = 1'b1;
            ram_we_s    = 1'b1;
            ram_addr_s  = {~front_r, bus.wr1_addr};
            ram_wdata_s = bus.wr1_data;
        end else begin
            ram_en_s = 1'b0;
            ram_we_s = 1'b0;
        end
    end

    assign bus.ram_en    = ram_en_s;
    assign bus.ram_we    = ram_we_s;
    assign bus.ram_addr  = ram_addr_s;
    assign bus.ram_wdata = ram_wdata_s;

    // Flip fires on the first pixel tick of the vblank line while pending.
    assign flip_s   = (state_r == ST_PEND) && pixel_tick &&
                      (x == 10'd0) && (y == VBLANK_LINE);
    assign swap_ack = flip_s;

    // Swap FSM; a request arriving while pending is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= swap_req ? ST_PEND : ST_IDLE;
                ST_PEND: state_r <= flip_s ? ST_IDLE : ST_PEND;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Front bank toggles on the edge closing the flip cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_r <= 1'b0;
        end else if (flip_s) begin
            front_r <= ~front_r;
        end else begin
            front_r <= front_r;
        end
    end

    assign front = front_r;

    // Remember what slot 0 did so the next cycle knows what to capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_disp_r  <= 1'b0;
            cap_blank_r <= 1'b0;
        end else begin
            cap_disp_r  <= display_slot_s;
            cap_blank_r <= pixel_tick & ~video_on;
        end
    end

    // Pixel register: RAM data after a display read, black after blank tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_data_r <= {DATA_W{1'b0}};
        end else if (cap_disp_r) begin
            pix_data_r <= bus.ram_rdata;
        end else if (cap_blank_r) begin
            pix_data_r <= {DATA_W{1'b0}};
        end else begin
            pix_data_r <= pix_data_r;
        end
    end

    assign pix_data = pix_data_r;

`ifdef FB_ARB_STATS_EN
    logic [15:0] starve0_r;
    logic [15:0] starve1_r;

    // Saturating counts of cycles each writer waited without a grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve0_r <= 16'h0000;
            starve1_r <= 16'h0000;
        end else begin
            if (bus.wr0_valid && !gnt_s[0] && (starve0_r != 16'hFFFF)) begin
                starve0_r <= starve0_r + 16'h0001;
            end else begin
                starve0_r <= starve0_r;
            end
            if (bus.wr1_valid && !gnt_s[1] && (starve1_r != 16'hFFFF)) begin
                starve1_r <= starve1_r + 16'h0001;
            end else begin
                starve1_r <= starve1_r;
            end
        end
    end

    assign starve0 = starve0_r;
    assign starve1 = starve1_r;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_arbiter
// Directed self-checking bench for fb_arbiter. Inputs change 1 ns after the
// rising edge; outputs are sampled mid-cycle.
// ---------------------------------------------------------------------------
module tb_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pixel_tick;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        swap_req;
    logic        swap_ack;
    logic [11:0] pix_data;
    logic        front;
`ifdef FB_ARB_STATS_EN
    logic [15:0] starve0;
    logic [15:0] starve1;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    fb_arbiter_if #(.DATA_W(12)) bus ();

    fb_arbiter #(.DATA_W(12), .FB_W(320), .FB_H(240)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pixel_tick (pixel_tick),
        .video_on   (video_on),
        .x          (x),
        .y          (y),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .pix_data   (pix_data),
        .front      (front),
`ifdef FB_ARB_STATS_EN
        .starve0    (starve0),
        .starve1    (starve1),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic tick, input logic von, input logic [9:0] xv, input logic [9:0] yv);
        pixel_tick = tick;
        video_on   = von;
        x          = xv;
        y          = yv;
    endtask

    initial begin
        reset_n       = 1'b0;
        pixel_tick    = 1'b0;
        video_on      = 1'b0;
        x             = 10'd0;
        y             = 10'd0;
        swap_req      = 1'b0;
        bus.wr0_valid = 1'b1;
        bus.wr0_addr  = 17'h00010;
        bus.wr0_data  = 12'h111;
        bus.wr1_valid = 1'b1;
        bus.wr1_addr  = 17'h1FFFF;
        bus.wr1_data  = 12'h222;
        bus.ram_rdata = 12'h000;

        // ---- reset state ----
        #3;
        chk("rst_pix", 32'(pix_data), 32'h0);
        chk("rst_front", 32'(front), 32'h0);
        chk("rst_ack", 32'(swap_ack), 32'h0);
        chk("rst_ram_en", 32'(bus.ram_en), 32'h0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'h0);
        chk("rst_rdy0", 32'(bus.wr0_ready), 32'h0);
        chk("rst_rdy1", 32'(bus.wr1_ready), 32'h0);
        cyc();
        cyc();
        reset_n = 1'b1;

        // ---- contention: slot0 no grant, then wr0, wr1, wr0 ----
        slot(1'b1, 1'b1, 10'd0, 10'd0);
        #2;
        chk("ct_s0_rdy", 32'({bus.wr1_ready, bus.wr0_ready}), 32'h0);
        chk("ct_s0_we", 32'(bus.ram_we), 32'h0);
        cyc();
        slot(1'b0, 1'b1, 10'd0, 10'd0);
        #2;
        chk("ct_s1_rdy", 32'({bus.wr1_ready, bus.wr0_ready}), 32'h1);
        chk("ct_s1_addr", 32'(bus.ram_addr), 32'h20010);
        chk("ct_s1_wdata", 32'(bus.ram_wdata), 32'h111);
        chk("ct_s1_we", 32'(bus.ram_we), 32'h1);
        cyc();
        #2;
        chk("ct_s2_rdy", 32'({bus.wr1_ready, bus.wr0_ready}), 32'h2);
        chk("ct_s2_addr", 32'(bus.ram_addr), 32'h3FFFF);
        chk("ct_s2_wdata", 32'(bus.ram_wdata), 32'h222);
        cyc();
        #2;
        chk("ct_s3_rdy", 32'({bus.wr1_ready, bus.wr0_ready}), 32'h1);
        cyc();
        slot(1'b1, 1'b1, 10'd0, 10'd0);
        #2;
        chk("ct_s0b_rdy", 32'({bus.wr1_ready, bus.wr0_ready}), 32'h0);
        cyc();

        // ---- display read: x=5, y=3 -> index 322 in bank 0 ----
        bus.wr0_valid = 1'b0;
        bus.wr1_valid = 1'b0;
        slot(1'b0, 1'b1, 10'd0, 10'd0);
        #2;
        chk("idle_en", 32'(bus.ram_en), 32'h0);
        cyc();
        slot(1'b1, 1'b1, 10'd5, 10'd3);
        #2;
        chk("dr_addr", 32'(bus.ram_addr), 32'd322);
        chk("dr_en", 32'(bus.ram_en), 32'h1);
        chk("dr_we", 32'(bus.ram_we), 32'h0);
        cyc();
        slot(1'b0, 1'b1, 10'd6, 10'd3);
        bus.ram_rdata = 12'hABC;
        #2;
        chk("dr_pix_lat", 32'(pix_data), 32'h0);
        cyc();
        bus.ram_rdata = 12'h555;
        #2;
        chk("dr_pix", 32'(pix_data), 32'hABC);
        cyc();
        #2;
        chk("dr_pix_hold", 32'(pix_data), 32'hABC);

        // ---- blanking: wr1 alone owns all 4 slots, pixel goes black ----
        bus.wr1_valid = 1'b1;
        bus.wr1_addr  = 17'h00042;
        bus.wr1_data  = 12'h777;
        cyc();
        slot(1'b1, 1'b0, 10'd0, 10'd0);
        #2;
        chk("bl_s0_rdy", 32'({bus.wr1_ready, bus.wr0_ready}), 32'h2);
        chk("bl_s0_addr", 32'(bus.ram_addr), 32'h20042);
        for (int i = 1; i < 4; i++) begin
            cyc();
            slot(1'b0, 1'b0, 10'd0, 10'd0);
            #2;
            chk("bl_sN_rdy", 32'({bus.wr1_ready, bus.wr0_ready}), 32'h2);
        end
        chk("bl_pix", 32'(pix_data), 32'h0);
        bus.wr1_valid = 1'b0;

        // ---- swap: request at y=100, flip only at x=0,y=480 tick ----
        cyc();
        slot(1'b0, 1'b1, 10'd0, 10'd100);
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        slot(1'b1, 1'b0, 10'd4, 10'd480);
        #2;
        chk("sw_ack_x4", 32'(swap_ack), 32'h0);
        cyc();
        slot(1'b0, 1'b0, 10'd0, 10'd480);
        #2;
        chk("sw_ack_notick", 32'(swap_ack), 32'h0);
        cyc();
        slot(1'b1, 1'b0, 10'd0, 10'd480);
        #2;
        chk("sw_ack", 32'(swap_ack), 32'h1);
        chk("sw_front_pre", 32'(front), 32'h0);
        cyc();
        slot(1'b0, 1'b0, 10'd0, 10'd480);
        bus.wr0_valid = 1'b1;
        bus.wr0_addr  = 17'h00005;
        #2;
        chk("sw_ack_pulse", 32'(swap_ack), 32'h0);
        chk("sw_front", 32'(front), 32'h1);
        chk("sw_wr_addr", 32'(bus.ram_addr), 32'h00005);
        bus.wr0_valid = 1'b0;

        // ---- reset while pending, with pix=0x123 and a capture in flight ----
        cyc();
        slot(1'b1, 1'b1, 10'd0, 10'd0);
        cyc();
        slot(1'b0, 1'b1, 10'd0, 10'd0);
        bus.ram_rdata = 12'h123;
        cyc();
        #2;
        chk("rp_pix", 32'(pix_data), 32'h123);
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        slot(1'b1, 1'b1, 10'd0, 10'd1);
        cyc();
        slot(1'b0, 1'b1, 10'd0, 10'd1);
        bus.ram_rdata = 12'h999;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rp_front", 32'(front), 32'h0);
        chk("rp_pix0", 32'(pix_data), 32'h0);
        cyc();
        reset_n = 1'b1;
        cyc();
        #2;
        chk("rp_no_capture", 32'(pix_data), 32'h0);
        slot(1'b1, 1'b0, 10'd0, 10'd480);
        #2;
        chk("rp_no_ack", 32'(swap_ack), 32'h0);
        cyc();
        slot(1'b0, 1'b0, 10'd0, 10'd480);
        #2;
        chk("rp_front_hold", 32'(front), 32'h0);

        // ---- request coincident with flip condition waits a frame ----
        cyc();
        slot(1'b1, 1'b0, 10'd0, 10'd480);
        swap_req = 1'b1;
        #2;
        chk("co_no_ack", 32'(swap_ack), 32'h0);
        cyc();
        swap_req = 1'b0;
        slot(1'b0, 1'b0, 10'd0, 10'd480);
        cyc();
        slot(1'b1, 1'b0, 10'd0, 10'd480);
        #2;
        chk("co_ack", 32'(swap_ack), 32'h1);
        cyc();
        slot(1'b0, 1'b0, 10'd0, 10'd480);
        #2;
        chk("co_front", 32'(front), 32'h1);

`ifdef FB_ARB_STATS_EN
        // ---- starvation counters ----
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        slot(1'b1, 1'b1, 10'd0, 10'd0);
        bus.wr0_valid = 1'b1;
        repeat (10) cyc();
        #2;
        chk("st_cnt0", 32'(starve0), 32'd10);
        chk("st_cnt1", 32'(starve1), 32'd0);
        dut.starve0_r = 16'hFFFD;
        repeat (5) cyc();
        #2;
        chk("st_sat", 32'(starve0), 32'hFFFF);
        bus.wr0_valid = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter: DATA_W, default 12, pixel width in bits.
REQ-002 Parameter: FB_W, default 320, framebuffer width in pixels (display 640 halved).
REQ-003 Parameter: FB_H, default 240, framebuffer height in pixels (display 480 halved).
REQ-004 Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- pixel_tick  in  1  one-cycle strobe every 4 clk from the timing generator.
- video_on  in  1  visible-area flag.
- x, y  in  10 each  current pixel coordinates.
- wr0_valid, wr1_valid  in  1 each  writer write requests.
- wr0_addr, wr1_addr  in  17 each  back-buffer pixel index.
- wr0_data, wr1_data  in  DATA_W each  write data.
- wr0_ready, wr1_ready  out  1 each  grant; a write is accepted in any cycle where valid && ready.
- swap_req  in  1  request a front/back buffer flip.
- swap_ack  out  1  one-cycle pulse when the flip takes effect.
- ram_en, ram_we  out  1 each  RAM strobes.
- ram_addr  out  18  {bank, index}.
- ram_wdata  out  DATA_W  write data to the RAM.
- ram_rdata  in  DATA_W  read data; synchronous RAM, 1-cycle read latency.
- pix_data  out  DATA_W  registered pixel to the DAC.
- front  out  1  current display bank.

Function
REQ-005 Each pixel period is 4 slots; slot 0 is the cycle in which pixel_tick=1.
REQ-006 Slot 0 with video_on=1 is the display slot: ram_en=1, ram_we=0, ram_addr={front, (y>>1)*FB_W + (x>>1)}; no writer is granted.
REQ-007 Slots 1-3, and every slot with video_on=0, are writer slots.
REQ-008 Writer slots arbitrate round-robin between wr0 and wr1: a lone requester wins; when both request, the one not granted last wins; the last-grant pointer updates only on an accepted write.
REQ-009 In a writer slot, the ready output is combinational and asserted only for the winner.
REQ-010 A granted write drives ram_en=1, ram_we=1, ram_addr={~front, wrN_addr}, ram_wdata=wrN_data in the same cycle.
REQ-011 An idle slot drives ram_en=0 and ram_we=0.
REQ-012 One cycle after a display slot, pix_data captures ram_rdata.
REQ-013 One cycle after a slot-0 cycle with video_on=0, pix_data is loaded with 0.
REQ-014 pix_data is otherwise held, giving a display latency of 2 clk from pixel_tick.
REQ-015 Swap FSM has two states, IDLE and PEND:
- IDLE -> PEND on swap_req=1.
- PEND -> IDLE on pixel_tick && x==0 && y==480; in that cycle front toggles and swap_ack=1 for one cycle.
REQ-016 swap_req while in PEND is ignored; no queuing.
REQ-017 A swap_req in the same cycle as the flip condition while IDLE enters PEND and waits for the next frame.
REQ-018 Writers see the new back bank starting the cycle after swap_ack.
REQ-019 Index arithmetic is 17 bits; wrN_addr >= FB_W*FB_H is not checked, and the RAM wraps it.

Reset
REQ-020 On reset_n=0, asynchronously: pix_data=0, front=0, swap FSM=IDLE, swap_ack=0, RR pointer points to wr0 (wr0 wins the first contention), and ram_en, ram_we, wr0_ready, wr1_ready are all 0.
REQ-021 Reset mid-operation discards any pending swap and any in-flight read capture.

Configuration
REQ-022 Macro FB_ARB_STATS_EN, when defined, adds outputs starve0 and starve1 (16 bits each). Each counts cycles with wrN_valid && !wrN_ready, saturates at 16'hFFFF, and clears on reset.
REQ-023 When FB_ARB_STATS_EN is not defined, the starve outputs and counters do not exist, and all other behaviour is unchanged.

Structure
REQ-024 A shared package holds the following:
- FB_W, FB_H, DATA_W defaults.
- FB_IDX_W=17 and FB_ADDR_W=18.
- The VBLANK_LINE=480 constant.
- The swap-state enum.
REQ-025 The round-robin grant logic is one sub-module, fb_rr2, with inputs req[1:0] and accept, and output gnt[1:0].

Verification
REQ-026 The bench covers the following directed scenarios:
- Display read: pixel_tick, video_on=1, x=5, y=3 -> ram_addr={0, 322}, ram_we=0; ram_rdata=0xABC on the next cycle -> pix_data=0xABC one cycle later.
- Contention: wr0_valid=wr1_valid=1 held over slots 1-3 after reset -> grants wr0, wr1, wr0, and no grant in slot 0.
- Blanking: video_on=0, wr1_valid only -> wr1_ready=1 in all 4 slots; pix_data=0 after the tick.
- Swap: swap_req at y=100 -> swap_ack exactly at the tick with x=0, y=480; front=1; the next wr0 write uses ram_addr[17]=0.
- Reset: reset_n low while in PEND with pix_data=0x123 -> front=0, pix_data=0, no swap_ack at the following frame.
- FB_ARB_STATS_EN defined: wr0_valid held 10 cycles during 10 slot-0 ticks -> starve0=10; forced near max -> holds at 0xFFFF.
